// File: rtl/alu_exec_unit_pkg.sv
// alu_exec_unit_pkg
//   Shared definitions for the execute-stage ALU: the ALU function codes
//   produced by the decoder, the FSM state encoding, and a small helper
//   that classifies shift operations.
package alu_exec_unit_pkg;

    localparam int ALU_FUNCT_WIDTH = 4;

    localparam logic [ALU_FUNCT_WIDTH-1:0] ALU_ADD = 4'd0;
    localparam logic [ALU_FUNCT_WIDTH-1:0] ALU_SUB = 4'd1;
    localparam logic [ALU_FUNCT_WIDTH-1:0] ALU_AND = 4'd2;
    localparam logic [ALU_FUNCT_WIDTH-1:0] ALU_OR  = 4'd3;
    localparam logic [ALU_FUNCT_WIDTH-1:0] ALU_XOR = 4'd4;
    localparam logic [ALU_FUNCT_WIDTH-1:0] ALU_SLT = 4'd5;
    localparam logic [ALU_FUNCT_WIDTH-1:0] ALU_SLL = 4'd6;
    localparam logic [ALU_FUNCT_WIDTH-1:0] ALU_SRL = 4'd7;
    localparam logic [ALU_FUNCT_WIDTH-1:0] ALU_SRA = 4'd8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } alu_state_e;

    // True for the three iterative shift operations.
    function automatic logic is_shift_op(input logic [ALU_FUNCT_WIDTH-1:0] funct);
        logic res;
        case (funct)
            ALU_SLL: res = 1'b1;
            ALU_SRL: res = 1'b1;
            ALU_SRA: res = 1'b1;
            default: res = 1'b0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/alu_exec_unit_shift.sv
// alu_shift_unit
//   Iterative one-bit-per-cycle shifter.
//   Ports:
//     clk, rst_n   - clock, async active-low reset
//     load         - capture operand/shamt/direction/arith flag
//     operand      - value to shift
//     shamt        - number of single-bit steps to perform
//     dir_left     - 1: shift left, 0: shift right
//     arith        - right shifts replicate the sign bit when set
//     value        - value the register takes after the current step
//     last         - current step is the final one
module alu_shift_unit
    import alu_exec_unit_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     load,
    input  logic [XLEN-1:0]          operand,
    input  logic [$clog2(XLEN)-1:0]  shamt,
    input  logic                     dir_left,
    input  logic                     arith,
    output logic [XLEN-1:0]          value,
    output logic                     last
);

    localparam int SW = $clog2(XLEN);
    localparam logic [SW-1:0] CNT_ZERO = SW'(0);
    localparam logic [SW-1:0] CNT_ONE  = SW'(1);

    logic [XLEN-1:0] shreg_r;
    logic [SW-1:0]   count_r;
    logic            left_r;
    logic            arith_r;
    logic [XLEN-1:0] step_s;

    // One-bit step; an arithmetic right shift keeps the MSB, which is the
    // original sign bit because it is never overwritten.
    always_comb begin
        step_s = shreg_r;
        if (left_r) begin
            step_s = {shreg_r[XLEN-2:0], 1'b0};
        end else begin
            step_s = {arith_r & shreg_r[XLEN-1], shreg_r[XLEN-1:1]};
        end
    end

    assign value = step_s;
    assign last  = (count_r == CNT_ONE);

    // Shift register and remaining-step counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg_r <= {XLEN{1'b0}};
            count_r <= CNT_ZERO;
            left_r  <= 1'b0;
            arith_r <= 1'b0;
        end else if (load) begin
            shreg_r <= operand;
            count_r <= shamt;
            left_r  <= dir_left;
            arith_r <= arith;
        end else if (count_r != CNT_ZERO) begin
            shreg_r <= step_s;
            count_r <= count_r - CNT_ONE;
        end else begin
            shreg_r <= shreg_r;
            count_r <= count_r;
        end
    end

endmodule

// File: rtl/alu_exec_unit.sv
// alu_exec_unit
//   Execute-stage ALU with valid/ready handshakes. Logical, arithmetic and
//   compare ops finish in one cycle; shifts step one bit per cycle.
//   Ports:
//     clk, rst_n          - clock, async active-low reset
//     in_valid/in_ready   - request handshake (in_ready high only when idle)
//     alu_funct           - operation code
//     operand_a/operand_b - operands (operand_b low bits = shift amount)
//     out_valid/out_ready - result handshake
//     result, zero        - registered result and result==0 flag
module alu_exec_unit
    import alu_exec_unit_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [ALU_FUNCT_WIDTH-1:0] alu_funct,
    input  logic [XLEN-1:0]            operand_a,
    input  logic [XLEN-1:0]            operand_b,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [XLEN-1:0]            result,
    output logic                       zero
);

    localparam int SW = $clog2(XLEN);

    alu_state_e       state_r;
    logic             in_ready_r;
    logic             out_valid_r;
    logic [XLEN-1:0]  result_r;
    logic             zero_r;

    logic [XLEN-1:0]  single_s;
    logic [SW-1:0]    shamt_s;
    logic             shift_op_s;
    logic             accept_s;
    logic             shift_load_s;
    logic [XLEN-1:0]  shift_value_s;
    logic             shift_last_s;

    assign shamt_s      = operand_b[SW-1:0];
    assign shift_op_s   = is_shift_op(alu_funct);
    assign accept_s     = in_valid && (state_r == ST_IDLE);
    assign shift_load_s = accept_s && shift_op_s && (shamt_s != SW'(0));

    // Single-cycle datapath; shift codes pass operand_a through, which is the
    // shamt==0 result.
    always_comb begin
        single_s = operand_a + operand_b;
        case (alu_funct)
            ALU_ADD: single_s = operand_a + operand_b;
            ALU_SUB: single_s = operand_a - operand_b;
            ALU_AND: single_s = operand_a & operand_b;
            ALU_OR:  single_s = operand_a | operand_b;
            ALU_XOR: single_s = operand_a ^ operand_b;
            ALU_SLT: single_s = {{(XLEN-1){1'b0}}, ($signed(operand_a) < $signed(operand_b))};
            ALU_SLL: single_s = operand_a;
            ALU_SRL: single_s = operand_a;
            ALU_SRA: single_s = operand_a;
            default: single_s = operand_a + operand_b;
        endcase
    end

    alu_shift_unit #(
        .XLEN (XLEN)
    ) u_shift (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (shift_load_s),
        .operand  (operand_a),
        .shamt    (shamt_s),
        .dir_left (alu_funct == ALU_SLL),
        .arith    (alu_funct == ALU_SRA),
        .value    (shift_value_s),
        .last     (shift_last_s)
    );

    // Control FSM with registered handshake outputs and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            result_r    <= {XLEN{1'b0}};
            zero_r      <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        in_ready_r <= 1'b0;
                        if (shift_load_s) begin
                            state_r <= ST_SHIFT;
                        end else begin
                            state_r     <= ST_DONE;
                            out_valid_r <= 1'b1;
                            result_r    <= single_s;
                            zero_r      <= (single_s == {XLEN{1'b0}});
                        end
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_SHIFT: begin
                    if (shift_last_s) begin
                        state_r     <= ST_DONE;
                        out_valid_r <= 1'b1;
                        result_r    <= shift_value_s;
                        zero_r      <= (shift_value_s == {XLEN{1'b0}});
                    end else begin
                        state_r <= ST_SHIFT;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state_r     <= ST_IDLE;
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                    end else begin
                        state_r <= ST_DONE;
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    in_ready_r  <= 1'b1;
                    out_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign result    = result_r;
    assign zero      = zero_r;

endmodule
